// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register (mode encodings and
// configuration legality check). Imported by the RTL and the testbench.
`timescale 1ns/1ps
package univ_shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;

  // Width needs at least two bits; counter must be able to hold WIDTH.
  function automatic bit usr_cfg_ok(input int unsigned width, input int unsigned cntw);
    return (width >= 2) && (cntw < 32) && ((64'(1) << cntw) > 64'(width));
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg.
//   master: drives EN, MODE, D, SIR, SIL; observes Q, SOR, SOL, CNT, DONE.
//   slave : the register itself.
`timescale 1ns/1ps
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
);
  import univ_shift_reg_pkg::*;

  logic              EN;
  logic [MODE_W-1:0] MODE;
  logic [WIDTH-1:0]  D;
  logic              SIR;
  logic              SIL;
  logic [WIDTH-1:0]  Q;
  logic              SOR;
  logic              SOL;
  logic [CNTW-1:0]   CNT;
  logic              DONE;

  modport master (output EN, MODE, D, SIR, SIL, input Q, SOR, SOL, CNT, DONE);
  modport slave  (input EN, MODE, D, SIR, SIL, output Q, SOR, SOL, CNT, DONE);
endinterface

// File: rtl/univ_shift_reg_bit_cell.sv
// usr_bit_cell: one storage bit of the universal shift register.
//   C, RN      : clock (rising) / async active-low reset
//   EN, MODE   : operation select, sampled on rising C
//   d          : parallel load bit
//   left_nb    : bit shifted in on right moves (SHR/ROR), from the higher index
//   right_nb   : bit shifted in on left moves (SHL/ROL), from the lower index
//   rst_bit    : value taken during reset
//   q          : stored bit
// Optional macro DELAY_MODEL_EN adds a TCQ clock-to-Q / reset-to-Q delay.
`timescale 1ns/1ps
module usr_bit_cell
  import univ_shift_reg_pkg::*;
#(
  parameter real TCQ = 1.5
) (
  input  logic              C,
  input  logic              RN,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic              d,
  input  logic              left_nb,
  input  logic              right_nb,
  input  logic              rst_bit,
  output logic              q
);

  logic q_q;
  logic q_d;

  if (TCQ < 0.0) begin : g_bad_tcq
    $error("usr_bit_cell: TCQ must be non-negative");
  end

  // Next-state mux; reserved encoding falls through to hold.
  always_comb begin
    q_d = q_q;
    if (EN) begin
      case (MODE)
        MODE_SHR, MODE_ROR: q_d = left_nb;
        MODE_SHL, MODE_ROL: q_d = right_nb;
        MODE_LOAD:          q_d = d;
        MODE_CLR:           q_d = 1'b0;
        default:            q_d = q_q;
      endcase
    end
  end

`ifdef DELAY_MODEL_EN
  always_ff @(posedge C or negedge RN) begin
    if (!RN) q_q <= #TCQ rst_bit;
    else     q_q <= #TCQ q_d;
  end
`else
  always_ff @(posedge C or negedge RN) begin
    if (!RN) q_q <= rst_bit;
    else     q_q <= q_d;
  end
`endif

  assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold, shift, rotate,
// load, sync clear) with a saturating shift counter and DONE flag.
//   C, RN : clock (rising) / async active-low reset
//   bus   : univ_shift_reg_if slave (EN, MODE, D, SIR, SIL in;
//           Q, SOR, SOL, CNT, DONE out). SOR/SOL are combinational from Q.
// Optional macro DELAY_MODEL_EN: Q, CNT, DONE update TCQ after the edge.
`timescale 1ns/1ps
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNTW      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter real              TCQ       = 1.5
) (
  input  logic                 C,
  input  logic                 RN,
  univ_shift_reg_if.slave      bus
);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);

  if (!usr_cfg_ok(WIDTH, CNTW)) begin : g_bad_cfg
    $error("univ_shift_reg: need WIDTH >= 2 and 2**CNTW > WIDTH");
  end

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] left_vec;
  logic [WIDTH-1:0] right_vec;
  logic             msb_in;
  logic             lsb_in;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic             done_q;
  logic             done_d;

  // End bits choose between serial input and wrap-around depending on mode.
  always_comb begin
    msb_in    = (bus.MODE == MODE_ROR) ? q_vec[0]       : bus.SIR;
    lsb_in    = (bus.MODE == MODE_ROL) ? q_vec[WIDTH-1] : bus.SIL;
    left_vec  = {msb_in, q_vec[WIDTH-1:1]};
    right_vec = {q_vec[WIDTH-2:0], lsb_in};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell #(
      .TCQ (TCQ)
    ) u_cell (
      .C        (C),
      .RN       (RN),
      .EN       (bus.EN),
      .MODE     (bus.MODE),
      .d        (bus.D[i]),
      .left_nb  (left_vec[i]),
      .right_nb (right_vec[i]),
      .rst_bit  (RESET_VAL[i]),
      .q        (q_vec[i])
    );
  end

  // Saturating shift counter; DONE tracks the post-edge count.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (bus.EN) begin
      case (bus.MODE)
        MODE_LOAD, MODE_CLR: cnt_d = '0;
        MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: begin
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNTW'(1);
        end
        default: cnt_d = cnt_q;
      endcase
      done_d = (cnt_d == CNT_MAX);
    end
  end

`ifdef DELAY_MODEL_EN
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      cnt_q  <= #TCQ '0;
      done_q <= #TCQ 1'b0;
    end else begin
      cnt_q  <= #TCQ cnt_d;
      done_q <= #TCQ done_d;
    end
  end
`else
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
`endif

  assign bus.Q    = q_vec;
  assign bus.SOR  = q_vec[0];
  assign bus.SOL  = q_vec[WIDTH-1];
  assign bus.CNT  = cnt_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=8, CNTW=4, RESET_VAL=8'hA5).
`timescale 1ns/1ps
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

`ifdef DELAY_MODEL_EN
  localparam real SETTLE = 2.0;
`else
  localparam real SETTLE = 0.5;
`endif

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sir;
    logic       sil;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  univ_shift_reg_if #(.WIDTH(8), .CNTW(4)) bus ();

  univ_shift_reg #(
    .WIDTH     (8),
    .CNTW      (4),
    .RESET_VAL (8'hA5),
    .TCQ       (1.5)
  ) dut (
    .C   (clk),
    .RN  (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] q, input logic [3:0] cnt,
                           input logic done);
    chk({tag, "_q"},    32'(bus.Q),    32'(q));
    chk({tag, "_cnt"},  32'(bus.CNT),  32'(cnt));
    chk({tag, "_done"}, 32'(bus.DONE), 32'(done));
    chk({tag, "_sor"},  32'(bus.SOR),  32'(q[0]));
    chk({tag, "_sol"},  32'(bus.SOL),  32'(q[7]));
  endtask

  task automatic drive(input logic en, input logic [2:0] mode, input logic [7:0] d,
                       input logic sir, input logic sil);
    bus.EN   = en;
    bus.MODE = mode;
    bus.D    = d;
    bus.SIR  = sir;
    bus.SIL  = sil;
  endtask

  task automatic step();
    @(posedge clk);
    #(SETTLE);
  endtask

  function automatic void add(input logic en, input logic [2:0] mode, input logic [7:0] d,
                              input logic sir, input logic sil, input logic [7:0] q,
                              input logic [3:0] cnt, input logic done);
    vec_t v;
    v = '{en, mode, d, sir, sil, q, cnt, done};
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] rol_exp [9];
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);

    // Vector table (starts from reset value A5).
    add(1, MODE_HOLD, 8'h00, 0, 0, 8'hA5, 4'd0, 0);
    add(1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 4'd0, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h40, 4'd1, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h20, 4'd2, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h10, 4'd3, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h08, 4'd4, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h04, 4'd5, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h02, 4'd6, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h01, 4'd7, 0);
    add(1, MODE_SHR,  8'hFF, 0, 0, 8'h00, 4'd8, 1);
    add(1, MODE_LOAD, 8'h01, 0, 0, 8'h01, 4'd0, 0);
    rol_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    for (int i = 0; i < 9; i++)
      add(1, MODE_ROL, 8'h00, 1, 1, rol_exp[i], (i >= 7) ? 4'd8 : 4'(i + 1), i >= 7);
    add(1, MODE_CLR,  8'h00, 0, 0, 8'h00, 4'd0, 0);
    add(1, MODE_LOAD, 8'h3C, 0, 0, 8'h3C, 4'd0, 0);
    add(1, 3'b111,    8'hFF, 1, 1, 8'h3C, 4'd0, 0);
    add(1, 3'b111,    8'hFF, 1, 1, 8'h3C, 4'd0, 0);
    add(1, MODE_CLR,  8'h00, 0, 0, 8'h00, 4'd0, 0);
    add(1, MODE_SHL,  8'h00, 0, 1, 8'h01, 4'd1, 0);
    add(1, MODE_SHL,  8'h00, 0, 1, 8'h03, 4'd2, 0);
    add(1, MODE_SHL,  8'h00, 0, 1, 8'h07, 4'd3, 0);
    for (int i = 0; i < 4; i++)
      add(0, MODE_LOAD, 8'hFF, 1, 1, 8'h07, 4'd3, 0);
    add(1, MODE_SHR,  8'h00, 1, 0, 8'h83, 4'd4, 0);
    add(1, MODE_ROR,  8'h00, 0, 0, 8'hC1, 4'd5, 0);
    add(1, MODE_SHL,  8'h00, 1, 0, 8'h82, 4'd6, 0);

    // Asynchronous reset dropped mid-cycle.
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #(SETTLE);
    chk_state("rst", 8'hA5, 4'd0, 1'b0);
    step();
    chk_state("rst_held", 8'hA5, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].en, vecs[k].mode, vecs[k].d, vecs[k].sir, vecs[k].sil);
      step();
      chk_state($sformatf("v%0d", k), vecs[k].q, vecs[k].cnt, vecs[k].done);
    end

    // Reset during the 4th of 8 shifts aborts immediately.
    drive(1, MODE_LOAD, 8'h81, 0, 0);
    step();
    drive(1, MODE_SHR, 8'h00, 0, 0);
    step();
    step();
    step();
    chk_state("mid_pre", 8'h10, 4'd3, 1'b0);
    #3;
    rst_n = 1'b0;
`ifdef DELAY_MODEL_EN
    #1.0;
    chk("mid_tcq_old_q", 32'(bus.Q), 32'h10);
    #1.0;
`else
    #(SETTLE);
`endif
    chk_state("mid_rst", 8'hA5, 4'd0, 1'b0);
    step();
    chk_state("mid_rst_held", 8'hA5, 4'd0, 1'b0);

    // Release just after an edge with SHR pending; next edge is the first op.
    drive(1, MODE_SHR, 8'h00, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #(SETTLE);
    chk_state("rel_wait", 8'hA5, 4'd0, 1'b0);
    step();
    chk_state("rel_first", 8'hD2, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; the next-generation successor to the single-bit DFF/DFFSR storage cells in the cell library.
- WIDTH-bit register with hold, shift, rotate, parallel-load and synchronous-clear modes.
- Built-in saturating shift counter with a DONE flag, so it works as a serialiser/deserialiser in the Tarea datapaths.
- Supports optional behavioural clock-to-Q delay, matching the delay-annotated cell library.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNTW, 4, shift-counter width; must satisfy 2**CNTW > WIDTH.
- RESET_VAL, 0, value Q takes during reset (WIDTH bits).
- TCQ, 1.5, clock-to-Q delay in time units; used only when DELAY_MODEL_EN is defined.

Ports:
- C  input  1  clock; rising-edge active.
- RN  input  1  asynchronous reset, active-low.
- EN  input  1  synchronous enable; 0 = hold everything.
- MODE  input  3  operation select (encoding in Behaviour).
- D  input  WIDTH  parallel load data.
- SIR  input  1  serial in for shift right (enters MSB).
- SIL  input  1  serial in for shift left (enters LSB).
- Q  output  WIDTH  register contents.
- SOR  output  1  serial out for right shift, = Q[0].
- SOL  output  1  serial out for left shift, = Q[WIDTH-1].
- CNT  output  CNTW  shifts/rotates since last load/clear, saturating.
- DONE  output  1  registered flag; 1 when CNT == WIDTH.

Behaviour:
- Reset (RN=0, asynchronous, immediate, independent of C):
  - Q=RESET_VAL, CNT=0, DONE=0.
  - Held while RN=0.
  - Release is synchronous in effect: the first active edge is the first rising C with RN=1.
- EN=0: Q, CNT and DONE hold regardless of MODE.
- EN=1, on rising C, MODE encoding:
  - 000 HOLD: Q unchanged.
  - 001 SHR: Q <= {SIR, Q[WIDTH-1:1]}.
  - 010 SHL: Q <= {Q[WIDTH-2:0], SIL}.
  - 011 LOAD: Q <= D.
  - 100 ROR: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 CLR: Q <= 0 (synchronous; not RESET_VAL).
  - 111 reserved, behaves as HOLD.
- Latency: one cycle; Q reflects the operation after the edge.
- SOR and SOL are combinational from Q and carry no extra latency.
- Counter rules:
  - LOAD or CLR: CNT <= 0.
  - SHR/SHL/ROR/ROL: CNT <= CNT+1 if CNT < WIDTH, else CNT stays at WIDTH (saturate, no wrap).
  - HOLD/reserved: CNT unchanged.
- DONE is registered: DONE <= (next CNT == WIDTH). It rises in the same cycle CNT reaches WIDTH and stays high until LOAD, CLR or reset.
- Boundary cases:
  - A shift at saturation still moves Q and leaves CNT=WIDTH, DONE=1.
  - LOAD issued while DONE=1 clears DONE on that edge.
  - RN asserted mid-shift sequence aborts it immediately; there is no partial update.
  - RN deasserting coincident with rising C: that edge is ignored, and the next edge is the first operation.
- MODE and D are sampled only at the rising C; changes between edges have no effect.

Optional Feature:
- Macro DELAY_MODEL_EN.
- Defined: Q, CNT and DONE update TCQ time units after rising C or after RN falling. SOR/SOL follow Q with no extra delay. Simulation-only timing model in line with the delayed NOT/NAND/NOR cells.
- Undefined: zero-delay, synthesizable nonblocking updates. The TCQ parameter is unused.
- Functional results at sampling points are identical in both builds.

Decomposition:
- Shared include/package usr_defs: the MODE_* localparams (HOLD, SHR, SHL, LOAD, ROR, ROL, CLR) and the WIDTH/CNTW legality check. This package is shared with the testbench.
- Sub-module usr_bit_cell: one bit of storage.
  - Inputs: C, RN, EN, MODE, d, left-neighbour, right-neighbour, reset bit.
  - Output: q.
  - Contains the 8:1 next-state mux plus async-low-reset flop.
  - Instantiated WIDTH times with generate.
- The counter and DONE logic live in the top level.

Test Plan:
- Reset with RESET_VAL=8'hA5: drop RN mid-cycle -> Q=8'hA5, CNT=0, DONE=0 immediately. EN=1 with MODE=HOLD after release -> Q stays 8'hA5.
- LOAD D=8'h81, then SHR with SIR=0 for 8 cycles -> SOR sequence 1,0,0,0,0,0,0,1. DONE=1 after the 8th edge, Q=8'h00, CNT=8.
- LOAD 8'h01, then ROL for 9 cycles -> Q=8'h80 after 7 edges, 8'h01 after 8, 8'h02 after 9. CNT saturates at 8; DONE stays 1.
- SHL with SIL=1 for 3 cycles, then EN=0 for 4 cycles with MODE=LOAD, D=8'hFF -> Q=8'h07 held, CNT=3 held.
- From DONE=1: issue CLR -> Q=0, CNT=0, DONE=0 on the same edge. MODE=111 for 2 cycles -> no change.
- Assert RN during the 4th of 8 shifts -> Q=RESET_VAL, CNT=0 without waiting for C. Repeat with DELAY_MODEL_EN defined and check the update lands at t+TCQ.
